// File: rtl/vram_pkg.sv
// vram_pkg: VRAM geometry, host command record, renderer slot schedule and timing window.
package vram_pkg;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 24576;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]    FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] TEXT_BASE  = 15'd0;
    localparam logic [ADDR_W-1:0] COLOR_BASE = 15'd10080;
    localparam logic [ADDR_W-1:0] FONT_BASE  = 15'd20160;
    localparam logic [ADDR_W-1:0] ADDR_END   = 15'd24576;

    localparam logic [11:0] H_VIS  = 12'd1440;
    localparam logic [11:0] H_PREF = 12'd1896;
    localparam logic [11:0] V_VIS  = 12'd896;
    localparam logic [11:0] V_PREF = 12'd931;

    // bit n set = renderer owns char-cycle slot n (slots 1, 3, 6)
    localparam logic [7:0] OWNED_SLOTS = 8'b0100_1010;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } host_cmd_t;

    function automatic logic in_window(input logic enable, input logic [11:0] h, input logic [11:0] v);
        return enable && (h < H_VIS || h >= H_PREF) && (v < V_VIS || v == V_PREF);
    endfunction
endpackage

// File: rtl/vram_bram.sv
// vram_bram: inferred single-port VRAM, read-first, registered q with no reset.
module vram_bram
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        q <= mem[addr];
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the VRAM between the renderer slot schedule and a FIFO-queued host port.
// Define VRAM_FONT_WP_EN to block host font-plane writes unless font_unlock is high.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [11:0]       h_counter,
    input  logic [11:0]       v_counter,
    input  logic [ADDR_W-1:0] render_addr,
    output logic [DATA_W-1:0] render_rdata,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              font_unlock
);
    host_cmd_t         fifo [FIFO_DEPTH];
    host_cmd_t         cmd, head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              owned, issue, push, in_range, wp, ram_we, rd_oor, q_live;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] q;

    assign cmd        = {host_we, host_addr, host_wdata};
    assign head       = fifo[rd_ptr];
    assign owned      = in_window(en, h_counter, v_counter) && OWNED_SLOTS[h_counter[2:0]];
    assign issue      = !owned && count != '0;
    assign host_ready = count != FIFO_FULL;
    assign push       = host_valid && host_ready;
    assign in_range   = head.addr < ADDR_END;

`ifdef VRAM_FONT_WP_EN
    assign wp = head.addr >= FONT_BASE && !font_unlock;
`else
    logic unused;
    assign unused = font_unlock;
    assign wp     = 1'b0;
`endif

    // dropped writes are still popped; only the RAM write strobe is suppressed
    assign ram_we   = issue && head.we && in_range && !wp;
    assign ram_addr = issue ? head.addr : render_addr;

    vram_bram u_bram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (head.wdata),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            host_rvalid <= 1'b0;
            rd_oor      <= 1'b0;
            q_live      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
            count       <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(issue);
            host_rvalid <= issue && !head.we;
            rd_oor      <= !in_range;
            q_live      <= 1'b1;
        end
    end

    // q has no reset, so both read outputs are masked until it holds a real read
    assign render_rdata = q_live ? q : '0;
    assign host_rdata   = (host_rvalid && !rd_oor) ? q : '0;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors for slot arbitration, host FIFO ordering, read return and reset.
module tb_vram_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, font_unlock = 1'b0;
    logic        host_valid = 1'b0, host_we = 1'b0;
    logic [11:0] h_counter = '0, v_counter = '0;
    logic [14:0] render_addr = '0, host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  render_rdata, host_rdata;
    logic        host_ready, host_rvalid;
    int          n_chk = 0, n_fail = 0;
    logic [7:0]  exp_q [$];

    typedef struct {
        logic        en;
        logic [11:0] h;
        logic [11:0] v;
        logic        issue;
    } vec_t;
    vec_t vecs [19];

    logic [14:0] ra [8];
    int          er [8];
    int          erd [8];

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .h_counter    (h_counter),
        .v_counter    (v_counter),
        .render_addr  (render_addr),
        .render_rdata (render_rdata),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .font_unlock  (font_unlock)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
        if (host_rvalid) begin
            if (exp_q.size() == 0) chk("unexpected_rvalid", {31'd0, host_rvalid}, 32'd0);
            else chk("host_rdata", {24'd0, host_rdata}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic push(input logic we, input logic [14:0] addr, input logic [7:0] data);
        for (int t = 0; t < 40 && !host_ready; t++) cyc();
        chk("push_ready", {31'd0, host_ready}, 32'd1);
        host_valid = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = data;
        cyc();
        host_valid = 1'b0;
    endtask

    task automatic wr(input logic [14:0] addr, input logic [7:0] data);
        push(1'b1, addr, data);
    endtask

    task automatic rd(input logic [14:0] addr, input logic [7:0] exp);
        exp_q.push_back(exp);
        push(1'b0, addr, 8'h00);
    endtask

    task automatic drain;
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) cyc();
        chk("drain_timeout", exp_q.size(), 32'd0);
        repeat (2) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{1'b1, 12'd1897, 12'd0,   1'b0}, '{1'b1, 12'd1896, 12'd0,   1'b1},
            '{1'b1, 12'd1899, 12'd0,   1'b0}, '{1'b1, 12'd1902, 12'd0,   1'b0},
            '{1'b1, 12'd1903, 12'd0,   1'b1}, '{1'b1, 12'd1,    12'd0,   1'b0},
            '{1'b1, 12'd2,    12'd0,   1'b1}, '{1'b1, 12'd4,    12'd0,   1'b1},
            '{1'b1, 12'd5,    12'd0,   1'b1}, '{1'b1, 12'd1433, 12'd0,   1'b0},
            '{1'b1, 12'd1439, 12'd0,   1'b1}, '{1'b1, 12'd1441, 12'd0,   1'b1},
            '{1'b1, 12'd1889, 12'd0,   1'b1}, '{1'b1, 12'd9,    12'd895, 1'b0},
            '{1'b1, 12'd9,    12'd896, 1'b1}, '{1'b1, 12'd9,    12'd930, 1'b1},
            '{1'b1, 12'd9,    12'd931, 1'b0}, '{1'b1, 12'd9,    12'd932, 1'b1},
            '{1'b0, 12'd9,    12'd0,   1'b1}
        };
        ra  = '{15'd7, 15'd0, 15'd7, 15'd10080, 15'd7, 15'd7, 15'd21200, 15'd7};
        er  = '{1, 0, 1, 1, 1, 1, 1, 1};
        erd = '{-1, 'h41, -1, 'h1F, -1, -1, 'h3C, -1};

        // reset held with a command offered: nothing may be accepted
        host_valid = 1'b1;
        repeat (3) cyc();
        chk("rst_ready", {31'd0, host_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("rst_render", {24'd0, render_rdata}, 32'd0);
        chk("rst_hrdata", {24'd0, host_rdata}, 32'd0);
        host_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            cyc();
            chk("post_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        end

        wr(15'd0, 8'h41);
        wr(15'd10080, 8'h1F);
        wr(15'd21200, 8'h3C);
        drain();

        // write then read of the same address back-to-back
        exp_q.push_back(8'h5A);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 15'd100; host_wdata = 8'h5A;
        cyc();
        host_we = 1'b0;
        cyc();
        host_valid = 1'b0;
        chk("raw_rvalid_early", {31'd0, host_rvalid}, 32'd0);
        cyc();
        chk("raw_rvalid", {31'd0, host_rvalid}, 32'd1);
        cyc();
        chk("raw_rvalid_pulse", {31'd0, host_rvalid}, 32'd0);
        drain();

        // five writes through one char cycle in the prefetch column
        en = 1'b1; h_counter = 12'd1897; v_counter = 12'd0; render_addr = 15'd7;
        for (int k = 0; k < 4; k++) wr(15'(200 + k), 8'(8'hA0 + k));
        chk("t2_full", {31'd0, host_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            h_counter   = 12'(1896 + i);
            render_addr = ra[i];
            host_valid  = (i == 1);
            host_we     = 1'b1;
            host_addr   = 15'd204;
            host_wdata  = 8'hA4;
            cyc();
            chk("t2_ready", {31'd0, host_ready}, er[i]);
            if (erd[i] >= 0) chk("t2_render", {24'd0, render_rdata}, erd[i]);
        end
        host_valid = 1'b0;

        // FIFO fills while owned slots stall issue
        h_counter = 12'd1897;
        for (int k = 0; k < 4; k++) begin
            chk("t4_ready", {31'd0, host_ready}, 32'd1);
            rd(15'(200 + k), 8'(8'hA0 + k));
        end
        chk("t4_full", {31'd0, host_ready}, 32'd0);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 15'd204;
        repeat (2) begin
            cyc();
            chk("t4_stall_rvalid", {31'd0, host_rvalid}, 32'd0);
            chk("t4_stall_ready", {31'd0, host_ready}, 32'd0);
        end
        host_valid = 1'b0;
        en = 1'b0;
        rd(15'd204, 8'hA4);
        rd(15'd100, 8'h5A);
        drain();

        for (int i = 0; i < 19; i++) begin
            en = 1'b1; h_counter = 12'd1897; v_counter = 12'd0;
            rd(15'd100, 8'h5A);
            en = vecs[i].en; h_counter = vecs[i].h; v_counter = vecs[i].v;
            cyc();
            chk($sformatf("vec%0d_issue", i), {31'd0, host_rvalid}, {31'd0, vecs[i].issue});
            en = 1'b0;
            drain();
        end

        font_unlock = 1'b1;
        wr(15'd20160, 8'h22);
        drain();
        font_unlock = 1'b0;
        wr(15'd20160, 8'hFF);
`ifdef VRAM_FONT_WP_EN
        rd(15'd20160, 8'h22);
`else
        rd(15'd20160, 8'hFF);
`endif
        wr(15'd20159, 8'h33);
        rd(15'd20159, 8'h33);
        drain();
        font_unlock = 1'b1;
        wr(15'd20160, 8'hFF);
        rd(15'd20160, 8'hFF);
        drain();

        wr(15'd24576, 8'h77);
        rd(15'd24576, 8'h00);
        rd(15'd32767, 8'h00);
        rd(15'd0, 8'h41);
        drain();

        // reset with queued reads: none may ever return
        en = 1'b1; h_counter = 12'd1897; v_counter = 12'd0;
        repeat (3) rd(15'd0, 8'h41);
        exp_q.delete();
        rst_n = 1'b0;
        repeat (2) begin
            cyc();
            chk("t5_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
            chk("t5_rst_render", {24'd0, render_rdata}, 32'd0);
            chk("t5_rst_ready", {31'd0, host_ready}, 32'd1);
        end
        rst_n = 1'b1;
        en = 1'b0;
        repeat (4) begin
            cyc();
            chk("t5_no_rvalid", {31'd0, host_rvalid}, 32'd0);
        end
        rd(15'd100, 8'h5A);
        rd(15'd0, 8'h41);
        rd(15'd21200, 8'h3C);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
